// File: rtl/sched_pkg.sv
// Shared widths, markers and encodings for the slot-schedule table writer.
package sched_pkg;

    localparam int              DEPTH    = 16;
    localparam int              IDX_W    = 4;
    localparam int              INFO_W   = 8;
    localparam logic [IDX_W-1:0] END_MARK = 4'hF;
    localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        OP_WR_ENTRY = 2'd0,
        OP_WR_INFO  = 2'd1,
        OP_COMMIT   = 2'd2,
        OP_CLEAR    = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMMIT_WAIT = 2'd1,
        COPY        = 2'd2,
        CLEAR       = 2'd3
    } state_e;

endpackage

// File: rtl/sched_table_writer_if.sv
// Host command port: valid/ready handshake carrying op, address and data.
interface sched_table_writer_if;

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;
    logic [sched_pkg::IDX_W-1:0]  cmd_addr;
    logic [sched_pkg::INFO_W-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/sched_bank_pair.sv
// Two register banks of entry/task-info tables: writes go to the shadow bank,
// registered scheduler reads and the copy-read port see the active bank.
module sched_bank_pair
    import sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active_bank,
    input  logic              i_entry_we,
    input  logic [IDX_W-1:0]  i_entry_addr,
    input  logic [IDX_W-1:0]  i_entry_data,
    input  logic              i_info_we,
    input  logic [IDX_W-1:0]  i_info_addr,
    input  logic [INFO_W-1:0] i_info_data,
    input  logic [IDX_W-1:0]  i_cp_idx,
    output logic [IDX_W-1:0]  o_cp_entry,
    output logic [INFO_W-1:0] o_cp_info,
    input  logic [IDX_W-1:0]  i_rd_entry_idx,
    output logic [IDX_W-1:0]  o_rd_entry_task,
    input  logic [IDX_W-1:0]  i_rd_task_no,
    output logic [INFO_W-1:0] o_rd_task_info
);

    logic [IDX_W-1:0]  r_entry [2][DEPTH];
    logic [INFO_W-1:0] r_info  [2][DEPTH];
    logic [IDX_W-1:0]  r_rd_entry_task;
    logic [INFO_W-1:0] r_rd_task_info;
    logic              w_shadow;

    assign w_shadow   = ~i_active_bank;
    assign o_cp_entry = r_entry[i_active_bank][i_cp_idx];
    assign o_cp_info  = r_info[i_active_bank][i_cp_idx];

    // NOTE: the tables are reset in full because an empty schedule must read
    // as END_MARK/zero; this keeps them in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_entry[b][i] <= END_MARK;
                    r_info[b][i]  <= '0;
                end
            end
            r_rd_entry_task <= END_MARK;
            r_rd_task_info  <= '0;
        end else begin
            if (i_entry_we) r_entry[w_shadow][i_entry_addr] <= i_entry_data;
            if (i_info_we)  r_info[w_shadow][i_info_addr]   <= i_info_data;
            r_rd_entry_task <= r_entry[i_active_bank][i_rd_entry_idx];
            r_rd_task_info  <= r_info[i_active_bank][i_rd_task_no];
        end
    end

    assign o_rd_entry_task = r_rd_entry_task;
    assign o_rd_task_info  = r_rd_task_info;

endmodule

// File: rtl/sched_table_writer.sv
// Command decode and commit/copy/clear FSM around the double-buffered tables;
// a commit only takes effect at a scheduler frame boundary.
module sched_table_writer
    import sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sched_table_writer_if.slave  cmd,
    input  logic                 frame_end,
    input  logic [IDX_W-1:0]     rd_entry_idx,
    output logic [IDX_W-1:0]     rd_entry_task,
    input  logic [IDX_W-1:0]     rd_task_no,
    output logic [INFO_W-1:0]    rd_task_info,
    output logic                 active_bank,
    output logic                 commit_pending,
    output logic                 err
);

    state_e            r_state;
    logic              r_cmd_ready;
    logic              r_active_bank;
    logic              r_commit_pending;
    logic              r_err;
    logic [IDX_W-1:0]  r_k;

    cmd_op_e           w_op;
    logic              w_accept;
    logic              w_entry_we;
    logic [IDX_W-1:0]  w_entry_addr;
    logic [IDX_W-1:0]  w_entry_data;
    logic              w_info_we;
    logic [IDX_W-1:0]  w_info_addr;
    logic [INFO_W-1:0] w_info_data;
    logic [IDX_W-1:0]  w_cp_entry;
    logic [INFO_W-1:0] w_cp_info;

    assign w_op     = cmd_op_e'(cmd.cmd_op);
    assign w_accept = cmd.cmd_valid && r_cmd_ready && (r_state == IDLE);

    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        w_entry_we   = 1'b0;
        w_entry_addr = r_k;
        w_entry_data = END_MARK;
        w_info_we    = 1'b0;
        w_info_addr  = r_k;
        w_info_data  = '0;
        unique case (r_state)
            IDLE: begin
                w_entry_addr = cmd.cmd_addr;
                w_entry_data = cmd.cmd_data[IDX_W-1:0];
                w_info_addr  = cmd.cmd_addr;
                w_info_data  = cmd.cmd_data;
                w_entry_we   = w_accept && (w_op == OP_WR_ENTRY);
                w_info_we    = w_accept && (w_op == OP_WR_INFO) && (cmd.cmd_addr != END_MARK);
            end
            COPY: begin
                w_entry_we   = 1'b1;
                w_entry_data = w_cp_entry;
                w_info_we    = 1'b1;
                w_info_data  = w_cp_info;
            end
            CLEAR: begin
                w_entry_we = 1'b1;
                w_info_we  = 1'b1;
            end
            COMMIT_WAIT: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_cmd_ready      <= 1'b0;
            r_active_bank    <= 1'b0;
            r_commit_pending <= 1'b0;
            r_err            <= 1'b0;
            r_k              <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        unique case (w_op)
                            OP_WR_ENTRY: ;
                            OP_WR_INFO:  r_err <= (cmd.cmd_addr == END_MARK);
                            OP_COMMIT: begin
                                r_state          <= COMMIT_WAIT;
                                r_commit_pending <= 1'b1;
                                r_cmd_ready      <= 1'b0;
                            end
                            OP_CLEAR: begin
                                r_state     <= CLEAR;
                                r_k         <= '0;
                                r_cmd_ready <= 1'b0;
                            end
                        endcase
                    end
                end
                COMMIT_WAIT: begin
                    if (frame_end) begin
                        r_active_bank    <= ~r_active_bank;
                        r_commit_pending <= 1'b0;
                        r_state          <= COPY;
                        r_k              <= '0;
                    end
                end
                COPY, CLEAR: begin
                    r_k <= r_k + IDX_W'(1);
                    if (r_k == LAST_K) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    sched_bank_pair u_banks (
        .clk             (clk),
        .rst             (rst),
        .i_active_bank   (r_active_bank),
        .i_entry_we      (w_entry_we),
        .i_entry_addr    (w_entry_addr),
        .i_entry_data    (w_entry_data),
        .i_info_we       (w_info_we),
        .i_info_addr     (w_info_addr),
        .i_info_data     (w_info_data),
        .i_cp_idx        (r_k),
        .o_cp_entry      (w_cp_entry),
        .o_cp_info       (w_cp_info),
        .i_rd_entry_idx  (rd_entry_idx),
        .o_rd_entry_task (rd_entry_task),
        .i_rd_task_no    (rd_task_no),
        .o_rd_task_info  (rd_task_info)
    );

    assign cmd.cmd_ready   = r_cmd_ready && rst;
    assign active_bank     = r_active_bank;
    assign commit_pending  = r_commit_pending;
    assign err             = r_err;

endmodule

// File: tb/tb_sched_table_writer.sv
// Directed scenarios for the double-buffered schedule table writer.
module tb_sched_table_writer;
    import sched_pkg::*;

    logic              clk;
    logic              rst;
    logic              frame_end;
    logic [IDX_W-1:0]  rd_entry_idx;
    logic [IDX_W-1:0]  rd_entry_task;
    logic [IDX_W-1:0]  rd_task_no;
    logic [INFO_W-1:0] rd_task_info;
    logic              active_bank;
    logic              commit_pending;
    logic              err;

    int checks = 0;
    int errors = 0;

    sched_table_writer_if cmd_if ();

    sched_table_writer dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd_if),
        .frame_end      (frame_end),
        .rd_entry_idx   (rd_entry_idx),
        .rd_entry_task  (rd_entry_task),
        .rd_task_no     (rd_task_no),
        .rd_task_info   (rd_task_info),
        .active_bank    (active_bank),
        .commit_pending (commit_pending),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input cmd_op_e op, input logic [IDX_W-1:0] addr, input logic [INFO_W-1:0] data);
        int n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_addr  = addr;
        cmd_if.cmd_data  = data;
        while (!cmd_if.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: cmd_ready got 0 for %0d cycles, required 1", n);
        end
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_if.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL ready_timeout: cmd_ready got 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", cmd_if.cmd_ready);
        end
        rst = 1'b1;
        rd_entry_idx = 4'd3;
        rd_task_no   = 4'd3;
        tick();
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b required 1", cmd_if.cmd_ready);
        end
        checks++;
        if (rd_entry_task !== 4'hF || rd_task_info !== 8'h00) begin
            errors++;
            $display("FAIL reset_reads: got %h/%h required f/00", rd_entry_task, rd_task_info);
        end
        checks++;
        if (active_bank !== 1'b0 || commit_pending !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got bank %b pend %b err %b required 0 0 0",
                     active_bank, commit_pending, err);
        end
    endtask

    task automatic test_commit_swap();
        int n_busy = 0;
        send(OP_WR_ENTRY, 4'd0, 8'h01);
        send(OP_WR_INFO, 4'd1, 8'h33);
        rd_entry_idx = 4'd0;
        rd_task_no   = 4'd1;
        tick();
        checks++;
        if (rd_entry_task !== 4'hF || rd_task_info !== 8'h00) begin
            errors++;
            $display("FAIL shadow_isolated: got %h/%h required f/00", rd_entry_task, rd_task_info);
        end
        send(OP_COMMIT, 4'd0, 8'h00);
        checks++;
        if (commit_pending !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_accept: got pend %b ready %b required 1 0",
                     commit_pending, cmd_if.cmd_ready);
        end
        tick(); tick();
        checks++;
        if (active_bank !== 1'b0 || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL commit_wait: got bank %b pend %b required 0 1", active_bank, commit_pending);
        end
        pulse_frame_end();
        checks++;
        if (active_bank !== 1'b1 || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL swap: got bank %b pend %b required 1 0", active_bank, commit_pending);
        end
        checks++;
        if (rd_entry_task !== 4'hF) begin
            errors++;
            $display("FAIL swap_edge_old_bank: got %h required f", rd_entry_task);
        end
        if (!cmd_if.cmd_ready) n_busy++;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (!cmd_if.cmd_ready) n_busy++;
            if (i == 1) begin
                checks++;
                if (rd_entry_task !== 4'h1 || rd_task_info !== 8'h33) begin
                    errors++;
                    $display("FAIL new_bank_reads: got %h/%h required 1/33", rd_entry_task, rd_task_info);
                end
            end
        end
        checks++;
        if (n_busy != 16 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL copy_busy: got %0d busy cycles ready %b required 16 1", n_busy, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_commit_same_cycle_frame_end();
        send(OP_WR_ENTRY, 4'd2, 8'h07);
        frame_end = 1'b1;
        send(OP_COMMIT, 4'd0, 8'h00);
        frame_end = 1'b0;
        checks++;
        if (active_bank !== 1'b1 || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_ignored: got bank %b pend %b required 1 1", active_bank, commit_pending);
        end
        for (int i = 0; i < 19; i++) tick();
        checks++;
        if (active_bank !== 1'b1 || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL still_waiting: got bank %b pend %b required 1 1", active_bank, commit_pending);
        end
        rd_entry_idx = 4'd2;
        pulse_frame_end();
        checks++;
        if (active_bank !== 1'b0 || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL late_swap: got bank %b pend %b required 0 0", active_bank, commit_pending);
        end
        tick();
        checks++;
        if (rd_entry_task !== 4'h7) begin
            errors++;
            $display("FAIL late_swap_read: got %h required 7", rd_entry_task);
        end
        wait_ready();
    endtask

    task automatic test_illegal_info();
        send(OP_WR_INFO, END_MARK, 8'h11);
        checks++;
        if (err !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse: got err %b ready %b required 1 1", err, cmd_if.cmd_ready);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: got %b required 0", err);
        end
        send(OP_COMMIT, 4'd0, 8'h00);
        tick();
        pulse_frame_end();
        rd_task_no   = END_MARK;
        rd_entry_idx = 4'd2;
        tick();
        checks++;
        if (rd_task_info !== 8'h00) begin
            errors++;
            $display("FAIL illegal_not_written: got %h required 00", rd_task_info);
        end
        checks++;
        if (rd_entry_task !== 4'h7) begin
            errors++;
            $display("FAIL copy_incremental: got %h required 7", rd_entry_task);
        end
        wait_ready();
    endtask

    task automatic test_clear();
        send(OP_CLEAR, 4'd0, 8'h00);
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy: got ready %b required 0", cmd_if.cmd_ready);
        end
        rd_entry_idx = 4'd0;
        rd_task_no   = 4'd1;
        tick();
        checks++;
        if (rd_entry_task !== 4'h1 || rd_task_info !== 8'h33) begin
            errors++;
            $display("FAIL clear_active_untouched: got %h/%h required 1/33", rd_entry_task, rd_task_info);
        end
        wait_ready();
        send(OP_COMMIT, 4'd0, 8'h00);
        pulse_frame_end();
        tick();
        checks++;
        if (rd_entry_task !== 4'hF || rd_task_info !== 8'h00 || active_bank !== 1'b0) begin
            errors++;
            $display("FAIL cleared_bank: got %h/%h bank %b required f/00 0",
                     rd_entry_task, rd_task_info, active_bank);
        end
        wait_ready();
    endtask

    task automatic test_reset_mid_copy();
        send(OP_WR_ENTRY, 4'd0, 8'h05);
        send(OP_WR_INFO, 4'd1, 8'h5A);
        send(OP_COMMIT, 4'd0, 8'h00);
        rd_entry_idx = 4'd0;
        rd_task_no   = 4'd1;
        pulse_frame_end();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (rd_entry_task !== 4'h5 || rd_task_info !== 8'h5A) begin
            errors++;
            $display("FAIL pre_reset_reads: got %h/%h required 5/5a", rd_entry_task, rd_task_info);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (active_bank !== 1'b0 || commit_pending !== 1'b0 || cmd_if.cmd_ready !== 1'b0 ||
            rd_entry_task !== 4'hF || rd_task_info !== 8'h00) begin
            errors++;
            $display("FAIL mid_copy_reset: got bank %b pend %b ready %b reads %h/%h required 0 0 0 f/00",
                     active_bank, commit_pending, cmd_if.cmd_ready, rd_entry_task, rd_task_info);
        end
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rd_entry_task !== 4'hF || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got read %h ready %b required f 1", rd_entry_task, cmd_if.cmd_ready);
        end
        send(OP_COMMIT, 4'd0, 8'h00);
        pulse_frame_end();
        tick();
        checks++;
        if (rd_entry_task !== 4'hF || rd_task_info !== 8'h00) begin
            errors++;
            $display("FAIL shadow_reset: got %h/%h required f/00", rd_entry_task, rd_task_info);
        end
        wait_ready();
    endtask

    initial begin
        rst              = 1'b0;
        frame_end        = 1'b0;
        rd_entry_idx     = '0;
        rd_task_no       = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_data  = '0;
        test_reset();
        test_commit_swap();
        test_commit_same_cycle_frame_end();
        test_illegal_info();
        test_clear();
        test_reset_mid_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sched_table_writer.md
Name: sched_table_writer

Overview:
- Owns the slot-schedule tables read by the task manager:
  - entry table: slot index -> task number
  - task-info table: task number -> {reload[7:4], budget[3:0]}
- Host programs a shadow bank through a valid/ready command port.
- A commit swaps shadow and active banks at the next scheduler frame boundary, so the schedule never changes mid-frame.
- Scheduler-side reads always come from the active bank.

Parameters:
- DEPTH, 16, number of schedule slots and number of task-info entries.
- IDX_W, 4, slot index and task number width.
- INFO_W, 8, task-info width: {reload[7:4], budget[3:0]}.
- END_MARK, 4'hF, task number that marks end of frame; task-info writes to this address are illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=WR_ENTRY, 1=WR_INFO, 2=COMMIT, 3=CLEAR
- cmd_addr  in  IDX_W  slot index (WR_ENTRY) or task number (WR_INFO)
- cmd_data  in  INFO_W  WR_ENTRY uses [IDX_W-1:0] as task number; WR_INFO uses all bits
- frame_end  in  1  one-cycle pulse from scheduler at slot-index wrap
- rd_entry_idx  in  IDX_W  scheduler slot lookup address
- rd_entry_task  out  IDX_W  active-bank entry[rd_entry_idx], registered
- rd_task_no  in  IDX_W  scheduler task-info lookup address
- rd_task_info  out  INFO_W  active-bank info[rd_task_no], registered
- active_bank  out  1  bank currently visible to scheduler
- commit_pending  out  1  commit accepted, swap not yet done
- err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (rst=0 at a clk edge):
  - both banks: all entries = END_MARK, all task-info = 0
  - state = IDLE; active_bank=0, commit_pending=0, err=0
  - rd_entry_task=END_MARK, rd_task_info=0
  - cmd_ready=0 while rst=0
- Reset asserted mid-COPY, mid-CLEAR or mid-COMMIT_WAIT aborts the operation; all state returns to reset values.
- Handshake:
  - A command transfers on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE; it is registered and deasserts the cycle after COMMIT or CLEAR is accepted.
  - The host must hold cmd_* stable while cmd_valid=1 and cmd_ready=0.
- WR_ENTRY: shadow entry[cmd_addr] <= cmd_data[IDX_W-1:0]. Any value is legal, including END_MARK.
- WR_INFO:
  - If cmd_addr == END_MARK: no write, err=1 for exactly one cycle. The handshake still completes.
  - Otherwise shadow info[cmd_addr] <= cmd_data.
- States:
  - IDLE: accept commands.
  - COMMIT_WAIT: entered when COMMIT is accepted; commit_pending=1.
    - A frame_end in the acceptance cycle is ignored.
    - On the first later frame_end: active_bank toggles, commit_pending=0, go to COPY.
  - COPY: DEPTH cycles; counter k=0..DEPTH-1 copies new-active entry[k] and info[k] into the shadow bank, so later edits are incremental. On k==DEPTH-1, return to IDLE.
  - CLEAR: DEPTH cycles; shadow entry[k]=END_MARK, info[k]=0. Active bank untouched. On k==DEPTH-1, return to IDLE.
- Read ports:
  - Latency is 1 cycle: outputs at edge N+1 reflect the address and active bank as sampled at edge N.
  - On the swap edge, reads sample the old bank; the cycle after, they use the new bank.
  - Reads are unaffected by shadow writes.
- frame_end in IDLE, COPY or CLEAR has no effect.
- The counter k is IDX_W wide and wraps 15->0 at exit. It is not reset by completion; it is zeroed on entry to COPY and CLEAR.

Decomposition:
- Shared package sched_pkg:
  - IDX_W, INFO_W, DEPTH, END_MARK
  - cmd_op encodings: OP_WR_ENTRY, OP_WR_INFO, OP_COMMIT, OP_CLEAR
  - FSM state encoding: IDLE, COMMIT_WAIT, COPY, CLEAR
- One natural sub-module: sched_bank_pair.
  - Two banks of entry and info registers.
  - Bank select, shadow write port, shadow read port for COPY, registered active read ports.
- The FSM, command decode and err logic stay in the top module.

Test Plan:
- After reset, rd_entry_idx=3 -> next cycle rd_entry_task=4'hF and rd_task_info=8'h00; cmd_ready=1 in the first cycle after rst=1.
- WR_ENTRY addr 0 data 1, WR_INFO addr 1 data 8'h33, COMMIT, then frame_end pulse -> active_bank 0->1 on that edge; next cycle rd_entry_idx=0 gives 4'h1 and rd_task_no=1 gives 8'h33; cmd_ready=0 for 16 cycles of COPY.
- COMMIT with frame_end in the same cycle -> no swap and commit_pending=1; swap happens only on the next frame_end, 20 cycles later.
- WR_INFO addr 4'hF data 8'h11 -> err high for one cycle, handshake completes, and that location still reads 8'h00 after commit.
- CLEAR following the committed setup -> active bank still reads 4'h1 at slot 0; after COMMIT and frame_end, slot 0 reads 4'hF.
- Assert rst at cycle 5 of COPY -> all reads are back to END_MARK/0, active_bank=0, commit_pending=0.
